// File: rtl/mems_scan_sequencer.sv
// MEMS scan sequencer: runs the init command words, then walks the raster
// (words/line, lines/frame, frames/scan) through the command ROM, one SPI start per word.
module mems_scan_sequencer #(
  parameter int unsigned ADDR_W          = 17,
  parameter int unsigned INIT_WORDS      = 2,
  parameter int unsigned SCAN_BASE       = 8,
  parameter int unsigned WORDS_PER_LINE  = 640,
  parameter int unsigned LINES_PER_FRAME = 59,
  parameter int unsigned FRAMES_PER_SCAN = 2,
  parameter int unsigned LINE_W          = 8,
  parameter int unsigned FRAME_W         = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mems_soft_reset,
  input  logic               pause,
  input  logic               mode_oneshot,
  input  logic               mems_SPI_busy,
  input  logic               new_line_FIFO_done,
  input  logic               new_frame_FIFO_done,
  output logic               mems_SPI_start,
  output logic [ADDR_W-1:0]  addr,
  output logic               new_line,
  output logic               new_frame,
  output logic [LINE_W-1:0]  line_idx,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               scan_done,
  output logic               overrun
);

  localparam int unsigned WORD_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  typedef enum logic [1:0] {IDLE, INIT, SCAN, DONE} state_t;

  state_t               state, state_nxt;
  logic [WORD_W-1:0]    word, word_nxt;
  logic                 soft_pend, soft_pend_nxt;
  logic                 start_nxt, new_line_nxt, new_frame_nxt, scan_done_nxt, overrun_nxt;
  logic [ADDR_W-1:0]    addr_nxt;
  logic [LINE_W-1:0]    line_nxt;
  logic [FRAME_W-1:0]   frame_nxt;
  logic                 set_line, set_frame, restart;
  logic                 slot, last_word, last_line, last_frame;

  // A start is only issued when busy is low and no start went out last cycle,
  // so the SPI master always gets a cycle to raise busy.
  assign slot       = !mems_SPI_busy && !mems_SPI_start;
  assign last_word  = (word == WORD_W'(WORDS_PER_LINE - 1));
  assign last_line  = (line_idx == LINE_W'(LINES_PER_FRAME - 1));
  assign last_frame = (frame_idx == FRAME_W'(FRAMES_PER_SCAN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      word           <= '0;
      soft_pend      <= 1'b0;
      mems_SPI_start <= 1'b0;
      addr           <= '0;
      new_line       <= 1'b0;
      new_frame      <= 1'b0;
      line_idx       <= '0;
      frame_idx      <= '0;
      scan_done      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      state          <= state_nxt;
      word           <= word_nxt;
      soft_pend      <= soft_pend_nxt;
      mems_SPI_start <= start_nxt;
      addr           <= addr_nxt;
      new_line       <= new_line_nxt;
      new_frame      <= new_frame_nxt;
      line_idx       <= line_nxt;
      frame_idx      <= frame_nxt;
      scan_done      <= scan_done_nxt;
      overrun        <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    word_nxt      = word;
    soft_pend_nxt = soft_pend;
    start_nxt     = 1'b0;
    addr_nxt      = addr;
    line_nxt      = line_idx;
    frame_nxt     = frame_idx;
    scan_done_nxt = scan_done;
    set_line      = 1'b0;
    set_frame     = 1'b0;
    restart       = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (mems_soft_reset) restart = 1'b1;
      end
      INIT: begin
        if (mems_soft_reset) soft_pend_nxt = 1'b1;
        if (slot) begin
          if (soft_pend || mems_soft_reset) begin
            restart = 1'b1;
          end else if (addr == ADDR_W'(INIT_WORDS - 1)) begin
            start_nxt = 1'b1;
            addr_nxt  = ADDR_W'(SCAN_BASE);
            word_nxt  = '0;
            line_nxt  = '0;
            frame_nxt = '0;
            state_nxt = SCAN;
          end else begin
            start_nxt = 1'b1;
            addr_nxt  = addr + ADDR_W'(1);
          end
        end
      end
      SCAN: begin
        if (mems_soft_reset) soft_pend_nxt = 1'b1;
        if (slot && (soft_pend || mems_soft_reset)) begin
          restart = 1'b1;
        end else if (slot && !pause) begin
          if (!last_word) begin
            start_nxt = 1'b1;
            addr_nxt  = addr + ADDR_W'(1);
            word_nxt  = word + WORD_W'(1);
          end else if (!last_line) begin
            start_nxt = 1'b1;
            set_line  = 1'b1;
            addr_nxt  = addr + ADDR_W'(1);
            word_nxt  = '0;
            line_nxt  = line_idx + LINE_W'(1);
          end else if (!last_frame) begin
            start_nxt = 1'b1;
            set_frame = 1'b1;
            addr_nxt  = addr + ADDR_W'(1);
            word_nxt  = '0;
            line_nxt  = '0;
            frame_nxt = frame_idx + FRAME_W'(1);
          end else begin
            set_frame = 1'b1;
            if (!mode_oneshot) begin
              start_nxt = 1'b1;
              addr_nxt  = ADDR_W'(SCAN_BASE);
              word_nxt  = '0;
              line_nxt  = '0;
              frame_nxt = '0;
            end else begin
              scan_done_nxt = 1'b1;
              state_nxt     = DONE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Set beats a simultaneous ack; a set on a still-unacked flag is an overrun.
    new_line_nxt  = set_line  | (new_line  & ~new_line_FIFO_done);
    new_frame_nxt = set_frame | (new_frame & ~new_frame_FIFO_done);
    overrun_nxt   = overrun
                  | (set_line  & new_line  & ~new_line_FIFO_done)
                  | (set_frame & new_frame & ~new_frame_FIFO_done);

    if (restart) begin
      state_nxt     = INIT;
      start_nxt     = 1'b1;
      addr_nxt      = '0;
      word_nxt      = '0;
      line_nxt      = '0;
      frame_nxt     = '0;
      soft_pend_nxt = 1'b0;
      scan_done_nxt = 1'b0;
      new_line_nxt  = 1'b0;
      new_frame_nxt = 1'b0;
      overrun_nxt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mems_scan_sequencer.sv
// Scoreboard bench for mems_scan_sequencer: expected SPI starts are queued as
// stimulus is applied and compared against every start the DUT issues.
module tb_mems_scan_sequencer;

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  line;
    logic [1:0]  frame;
    logic        nl;
    logic        nf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mems_soft_reset = 1'b0;
  logic        pause = 1'b0;
  logic        mode_oneshot = 1'b0;
  logic        mems_SPI_busy;
  logic        new_line_FIFO_done;
  logic        new_frame_FIFO_done;
  logic        mems_SPI_start;
  logic [16:0] addr;
  logic        new_line;
  logic        new_frame;
  logic [7:0]  line_idx;
  logic [1:0]  frame_idx;
  logic        scan_done;
  logic        overrun;

  logic        ack_en = 1'b1;
  logic        man_nl_ack = 1'b0;
  logic [1:0]  busy_cnt = '0;
  logic [7:0]  nl_age = '0;
  logic [7:0]  nf_age = '0;
  bit          prev_start = 1'b0;
  bit          m_nl = 1'b0;
  bit          m_nf = 1'b0;
  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  mems_scan_sequencer #(
    .ADDR_W(17), .INIT_WORDS(2), .SCAN_BASE(8), .WORDS_PER_LINE(4),
    .LINES_PER_FRAME(3), .FRAMES_PER_SCAN(2), .LINE_W(8), .FRAME_W(2)
  ) dut (
    .clk(clk), .rst(rst), .mems_soft_reset(mems_soft_reset), .pause(pause),
    .mode_oneshot(mode_oneshot), .mems_SPI_busy(mems_SPI_busy),
    .new_line_FIFO_done(new_line_FIFO_done), .new_frame_FIFO_done(new_frame_FIFO_done),
    .mems_SPI_start(mems_SPI_start), .addr(addr), .new_line(new_line),
    .new_frame(new_frame), .line_idx(line_idx), .frame_idx(frame_idx),
    .scan_done(scan_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // SPI master model: busy for three cycles, rising the cycle after each start.
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= '0;
    else if (mems_SPI_start) busy_cnt <= 2'd3;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 2'd1;
  end
  assign mems_SPI_busy = (busy_cnt != 0);

  // FIFO model: acks a marker two cycles after it rises.
  always @(posedge clk) begin
    nl_age <= !new_line  ? 8'd0 : (nl_age == 8'hff ? nl_age : nl_age + 8'd1);
    nf_age <= !new_frame ? 8'd0 : (nf_age == 8'hff ? nf_age : nf_age + 8'd1);
  end
  assign new_line_FIFO_done  = (ack_en && nl_age == 8'd1) || man_nl_ack;
  assign new_frame_FIFO_done = ack_en && nf_age == 8'd1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected start for ROM address a (scan raster 4 words x 3 lines x 2 frames at base 8).
  task automatic push_word(input int a, input bit wrap, input bit acked);
    exp_t e;
    int idx, f, l, w;
    bit snl, snf;
    if (a < 8) begin
      f = 0; l = 0; snl = 0; snf = 0;
    end else begin
      idx = a - 8;
      f = idx / 12;
      l = (idx % 12) / 4;
      w = idx % 4;
      snl = (w == 0) && (l != 0);
      snf = (w == 0) && (l == 0) && ((f != 0) || wrap);
    end
    if (acked) begin
      m_nl = snl; m_nf = snf;
    end else begin
      m_nl = m_nl | snl; m_nf = m_nf | snf;
    end
    e.addr = 17'(a); e.line = 8'(l); e.frame = 2'(f); e.nl = m_nl; e.nf = m_nf;
    q.push_back(e);
  endtask

  task automatic push_range(input int lo, input int hi, input bit acked);
    for (int a = lo; a <= hi; a++) push_word(a, 1'b0, acked);
  endtask

  task automatic pulse_soft();
    @(negedge clk);
    mems_soft_reset = 1'b1;
    @(negedge clk);
    mems_soft_reset = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq(tag, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  // Scoreboard monitor: every start must be expected, one cycle wide, and issued while idle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && mems_SPI_start) begin
      check_eq("start_while_busy", 32'(mems_SPI_busy), 32'd0);
      check_eq("start_width", 32'(prev_start), 32'd0);
      check_eq("start_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check_eq("sb_addr", 32'(addr), 32'(e.addr));
        check_eq("sb_line_idx", 32'(line_idx), 32'(e.line));
        check_eq("sb_frame_idx", 32'(frame_idx), 32'(e.frame));
        check_eq("sb_new_line", 32'(new_line), 32'(e.nl));
        check_eq("sb_new_frame", 32'(new_frame), 32'(e.nf));
      end
    end
    prev_start = mems_SPI_start;
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_start", 32'(mems_SPI_start), 32'd0);
    check_eq("rst_addr", 32'(addr), 32'd0);
    check_eq("rst_new_line", 32'(new_line), 32'd0);
    check_eq("rst_new_frame", 32'(new_frame), 32'd0);
    check_eq("rst_scan_done", 32'(scan_done), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;

    // Init sequence, full continuous scan, wrap back to the first scan word
    push_word(0, 1'b0, 1'b1);
    push_word(1, 1'b0, 1'b1);
    push_range(8, 31, 1'b1);
    push_word(8, 1'b1, 1'b1);
    pulse_soft();
    wait_empty("continuous_scan");
    check_eq("no_overrun_acked", 32'(overrun), 32'd0);

    // One-shot: the second pass ends in DONE
    mode_oneshot = 1'b1;
    push_range(9, 31, 1'b1);
    wait_empty("oneshot_scan");
    n = 0;
    while (!scan_done && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("scan_done_set", 32'(scan_done), 32'd1);
    check_eq("done_new_frame", 32'(new_frame), 32'd1);
    check_eq("done_addr", 32'(addr), 32'd31);
    check_eq("done_line_idx", 32'(line_idx), 32'd2);
    check_eq("done_frame_idx", 32'(frame_idx), 32'd1);
    repeat (20) @(negedge clk);
    #1;
    check_eq("done_addr_hold", 32'(addr), 32'd31);
    check_eq("done_hold", 32'(scan_done), 32'd1);

    // Restart from DONE with acks withheld: overrun on the second line marker
    mode_oneshot = 1'b0;
    ack_en = 1'b0;
    m_nl = 1'b0; m_nf = 1'b0;
    push_word(0, 1'b0, 1'b0);
    push_word(1, 1'b0, 1'b0);
    push_range(8, 15, 1'b0);
    pulse_soft();
    wait_empty("noack_to_15");
    check_eq("scan_done_cleared", 32'(scan_done), 32'd0);
    check_eq("overrun_before", 32'(overrun), 32'd0);
    push_word(16, 1'b0, 1'b0);
    wait_empty("noack_16");
    pause = 1'b1;
    check_eq("overrun_set", 32'(overrun), 32'd1);

    // Soft reset while paused in SCAN; then ack held across a line set
    ack_en = 1'b1;
    man_nl_ack = 1'b1;
    m_nl = 1'b0; m_nf = 1'b0;
    push_word(0, 1'b0, 1'b1);
    push_word(1, 1'b0, 1'b1);
    push_word(8, 1'b0, 1'b1);
    pulse_soft();
    wait_empty("restart_paused");
    check_eq("overrun_cleared", 32'(overrun), 32'd0);
    check_eq("line_cleared", 32'(new_line), 32'd0);
    push_range(9, 12, 1'b1);
    pause = 1'b0;
    wait_empty("collision_run");
    push_word(13, 1'b0, 1'b1);
    @(negedge clk); #1;
    check_eq("collision_cleared_after", 32'(new_line), 32'd0);
    check_eq("collision_no_overrun", 32'(overrun), 32'd0);
    man_nl_ack = 1'b0;
    wait_empty("to_13");

    // Pause holds the scan at 13
    pause = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check_eq("pause_addr", 32'(addr), 32'd13);
    push_range(14, 22, 1'b1);
    pause = 1'b0;
    wait_empty("resume_to_22");

    // Soft reset during the transfer of 22 waits for busy to fall
    repeat (2) @(negedge clk);
    #1;
    check_eq("busy_at_soft_reset", 32'(mems_SPI_busy), 32'd1);
    pause = 1'b1;
    m_nl = 1'b0; m_nf = 1'b0;
    push_word(0, 1'b0, 1'b1);
    push_word(1, 1'b0, 1'b1);
    push_word(8, 1'b0, 1'b1);
    pulse_soft();
    wait_empty("restart_mid_transfer");

    // Async reset mid-transfer clears outputs without a clock edge
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("arst_start", 32'(mems_SPI_start), 32'd0);
    check_eq("arst_addr", 32'(addr), 32'd0);
    check_eq("arst_line_idx", 32'(line_idx), 32'd0);
    check_eq("arst_frame_idx", 32'(frame_idx), 32'd0);
    check_eq("arst_new_line", 32'(new_line), 32'd0);
    check_eq("arst_new_frame", 32'(new_frame), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mems_scan_sequencer.md
Name: mems_scan_sequencer

Overview:
Parametrised successor to the MEMS SPI control sequencer. After a soft-reset request it sends a fixed init command sequence, then walks a configurable raster (words per line, lines per frame, frames per scan) through the MEMS command ROM. Each word is one SPI start handshake. It raises line and frame markers for the FIFO side, and adds one-shot mode, position outputs, overrun detection and soft-reset restart from any state. It sits between the MEMS SPI master, the command ROM (addr) and the FIFO line/frame logic.

Parameters:
ADDR_W, 17, ROM address width
INIT_WORDS, 2, init command words at ROM addresses 0..INIT_WORDS-1 (>=1)
SCAN_BASE, 8, ROM address of the first scan word (>= INIT_WORDS)
WORDS_PER_LINE, 640, ROM words per scan line (>=2)
LINES_PER_FRAME, 59, lines per frame (>=1)
FRAMES_PER_SCAN, 2, frames per full scan (>=1)
LINE_W, 8, width of line_idx (must hold LINES_PER_FRAME-1)
FRAME_W, 2, width of frame_idx (must hold FRAMES_PER_SCAN-1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
mems_soft_reset  in  1  request: (re)run init sequence then scan
pause  in  1  1 = hold scan (no new SPI starts in SCAN)
mode_oneshot  in  1  1 = stop after one full scan; 0 = wrap continuously
mems_SPI_busy  in  1  SPI master busy
new_line_FIFO_done  in  1  ack: clears new_line
new_frame_FIFO_done  in  1  ack: clears new_frame
mems_SPI_start  out  1  one-cycle start pulse for the word at addr
addr  out  ADDR_W  ROM address of the current/last issued word
new_line  out  1  line-end marker, held until ack
new_frame  out  1  frame-end marker, held until ack
line_idx  out  LINE_W  line of the last issued scan word
frame_idx  out  FRAME_W  frame of the last issued scan word
scan_done  out  1  one-shot scan complete (DONE state)
overrun  out  1  sticky: a marker was re-raised before its ack

Behaviour:
- Async reset: state=IDLE; all outputs 0; internal word counter 0.
- Issue slot = cycle with mems_SPI_busy==0 and mems_SPI_start==0. This guarantees one cycle for busy to rise. Registered outputs: addr and start update together on the cycle after the slot. addr holds until the next start.
- States: IDLE, INIT, SCAN, DONE.
- IDLE/DONE: start=0, addr holds (IDLE: 0). On mems_soft_reset: start=1, addr=0, counters/flags/overrun/scan_done cleared, go INIT.
- INIT: at each issue slot, if addr==INIT_WORDS-1: start with addr=SCAN_BASE, word=line=frame=0, go SCAN. Otherwise start with addr+1. pause is ignored in INIT.
- SCAN: at an issue slot with pause==0, evaluate the position of addr (last issued word):
  - Mid-line: addr+1, word+1.
  - Last word of a line, not last line of the frame: set new_line, line+1, word=0, addr+1.
  - Last word of the last line of a frame, not the last frame: set new_frame only (new_line not set), line=0, frame+1, addr+1.
  - Last word of the scan (addr = SCAN_BASE + WPL*LPF*FPS - 1): set new_frame. Then:
    - mode_oneshot==0: start with addr=SCAN_BASE and counters 0.
    - mode_oneshot==1: no start, addr holds, scan_done=1, go DONE.
  - Markers assert in the same cycle as the accompanying start (or as scan_done).
- Marker ack: FIFO_done clears its flag on the next cycle. Simultaneous set and ack of the same flag: set wins (flag stays 1). Set while the flag is already 1 with no ack that cycle: flag stays 1, overrun=1 (sticky until rst or soft reset).
- mems_soft_reset in INIT/SCAN: latched as pending. At the next issue slot (pause ignored), acts as the IDLE transition: start with addr=0, clear state, go INIT. The current SPI transfer is never cut.
- Ack inputs are honoured in every state.

Test Plan:
Params for all: INIT_WORDS=2, SCAN_BASE=8, WPL=4, LPF=3, FPS=2; scan addresses 8..31; SPI model asserts busy 3 cycles after each start.
1. Init: rst, then 1-cycle mems_soft_reset -> starts with addr 0, 1, 8 in order; each start exactly 1 cycle; no start while busy.
2. Markers, continuous, ack 2 cycles after rise:
   - new_line rises with start of addr 12; frame_idx/line_idx 0/1.
   - new_frame (not new_line) rises with start of addr 20.
   - After addr 31 the next start carries addr 8 with new_frame=1.
   - overrun stays 0.
3. One-shot: mode_oneshot=1 -> after addr 31 no further start, scan_done=1, new_frame=1, addr=31. A later soft reset restarts at addr 0.
4. Overrun and collision:
   - Never ack -> overrun=1 at the start of addr 16.
   - Separately, ack in the same cycle as a set -> flag stays 1, overrun stays 0.
5. Pause: assert pause at addr 13 -> no starts and addr stable for 20 cycles. Release -> next start carries addr 14.
6. Restart and reset:
   - mems_soft_reset at addr 22 while busy -> after busy falls, start with addr 0, flags cleared.
   - Async rst mid-transfer -> all outputs 0 immediately, no clock edge needed.
